pwm_compare: RTL and testbench

Compare/PWM stage fed directly by the free-running wrap-around counter. It samples the counter value every clock and detects period boundaries (wraps) and duty-threshold crossings. It produces a registered PWM level, one-cycle wrap and match pulses, and a period count. New duty values arrive over a valid/ready handshake into a shadow register and take effect only at a period boundary, so the output has no glitches when the duty changes.

---
 rtl/pwm_compare.sv | 156 +++++++++++++++
 tb/tb_pwm_compare.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_compare.sv
// pwm_compare
//    Compare/PWM stage driven by an external free-running wrap-around counter.
//    Every clock it samples cnt, detects period boundaries (cnt going down) and
//    duty-threshold crossings. It produces a registered PWM level, one-cycle
//    wrap/match pulses and a count of periods seen while running. New duty
//    values are loaded through a valid/ready handshake into a shadow register.
//    The shadow value is committed only on a wrap, so a duty change never
//    glitches the PWM mid-period.
//
// Ports
//    clk          clock, all logic on posedge
//    rst          synchronous active-high reset
//    cnt          counter value from upstream counter
//    en           run enable
//    ld_valid     new duty offered
//    ld_duty      offered duty value
//    ld_ready     shadow register empty (decode of shadow_full)
//    pwm          registered PWM level
//    wrap_pulse   one-cycle pulse per detected wrap (SYNC/RUN)
//    match_pulse  one-cycle pulse on duty-threshold crossing (RUN)
//    running      high while in RUN
//    period_cnt   wraps seen in RUN, modulo 2^PER_W
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | disabled, outputs held low, waiting for en
// SYNC  | enabled, waiting for the first wrap to align to a period start
// RUN   | generating pwm, match pulses and counting periods

module pwm_compare #(
   parameter int CNT_W     = 16,
   parameter int INIT_DUTY = 0,
   parameter int PER_W     = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [CNT_W-1:0] cnt,
   input  logic             en,
   input  logic             ld_valid,
   input  logic [CNT_W-1:0] ld_duty,
   output logic             ld_ready,
   output logic             pwm,
   output logic             wrap_pulse,
   output logic             match_pulse,
   output logic             running,
   output logic [PER_W-1:0] period_cnt
);

   typedef enum logic [1:0] {IDLE, SYNC, RUN} state_t;

   localparam logic [CNT_W-1:0] DUTY_RST = CNT_W'(INIT_DUTY);

   state_t           state;
   logic [CNT_W-1:0] cnt_prev;
   logic             prev_vld;
   logic [CNT_W-1:0] duty_act;
   logic [CNT_W-1:0] shadow;
   logic             shadow_full;

   logic             wrap;
   logic             commit;
   logic             ld_xfer;
   logic [CNT_W-1:0] duty_eff;
   logic             match_hit;

   assign wrap     = prev_vld && (cnt < cnt_prev);
   assign commit   = wrap && shadow_full && (state != IDLE);
   assign ld_ready = !shadow_full;
   assign ld_xfer  = ld_valid && ld_ready;
   // The compare in a wrap cycle already belongs to the new period.
   assign duty_eff = commit ? shadow : duty_act;

   // On a wrap the previous sample is from the old period, so only the upper
   // bound is tested. Otherwise a crossing is detected as an interval test so
   // that a counter stepping by more than one cannot jump over the duty.
   assign match_hit = wrap ? (duty_eff <= cnt)
                           : ((cnt_prev < duty_eff) && (duty_eff <= cnt));

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         cnt_prev    <= '0;
         prev_vld    <= 1'b0;
         duty_act    <= DUTY_RST;
         shadow      <= '0;
         shadow_full <= 1'b0;
         pwm         <= 1'b0;
         wrap_pulse  <= 1'b0;
         match_pulse <= 1'b0;
         running     <= 1'b0;
         period_cnt  <= '0;
      end else begin
         cnt_prev <= cnt;
         prev_vld <= 1'b1;

         // commit implies shadow_full, so ld_xfer cannot be active with it
         if (commit) begin
            duty_act    <= shadow;
            shadow_full <= 1'b0;
         end else if (ld_xfer) begin
            shadow      <= ld_duty;
            shadow_full <= 1'b1;
         end

         case (state)
            IDLE: begin
               pwm         <= 1'b0;
               wrap_pulse  <= 1'b0;
               match_pulse <= 1'b0;
               running     <= 1'b0;
               if (en) state <= SYNC;
            end
            SYNC: begin
               pwm         <= 1'b0;
               match_pulse <= 1'b0;
               if (!en) begin
                  state      <= IDLE;
                  wrap_pulse <= 1'b0;
                  running    <= 1'b0;
               end else begin
                  wrap_pulse <= wrap;
                  if (wrap) begin
                     state   <= RUN;
                     running <= 1'b1;
                  end else begin
                     running <= 1'b0;
                  end
               end
            end
            RUN: begin
               if (!en) begin
                  state       <= IDLE;
                  pwm         <= 1'b0;
                  wrap_pulse  <= 1'b0;
                  match_pulse <= 1'b0;
                  running     <= 1'b0;
               end else begin
                  pwm         <= (cnt < duty_eff);
                  wrap_pulse  <= wrap;
                  match_pulse <= match_hit;
                  running     <= 1'b1;
                  if (wrap) period_cnt <= period_cnt + PER_W'(1);
               end
            end
            default: begin
               state       <= IDLE;
               pwm         <= 1'b0;
               wrap_pulse  <= 1'b0;
               match_pulse <= 1'b0;
               running     <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_pwm_compare.sv
// Directed bench for pwm_compare with CNT_W=4, INIT_DUTY=3, PER_W=4.
// The counter is driven directly; per-sequence masks record which sample
// index (bit k = k-th clock of the sequence) saw each output high.

module tb_pwm_compare;

   logic       clk;
   logic       rst;
   logic [3:0] cnt;
   logic       en;
   logic       ld_valid;
   logic [3:0] ld_duty;
   logic       ld_ready;
   logic       pwm;
   logic       wrap_pulse;
   logic       match_pulse;
   logic       running;
   logic [3:0] period_cnt;

   int checks = 0;
   int errors = 0;

   int ld_q[$];
   logic [31:0] pwm_mask, match_mask, wrap_mask, rdy_mask, acc_mask;

   pwm_compare #(.CNT_W(4), .INIT_DUTY(3), .PER_W(4)) dut (
      .clk         (clk),
      .rst         (rst),
      .cnt         (cnt),
      .en          (en),
      .ld_valid    (ld_valid),
      .ld_duty     (ld_duty),
      .ld_ready    (ld_ready),
      .pwm         (pwm),
      .wrap_pulse  (wrap_pulse),
      .match_pulse (match_pulse),
      .running     (running),
      .period_cnt  (period_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Drive one counter sample and advance one clock; offers the head of the
   // load queue and pops it if the handshake completed on this edge.
   task automatic tick(input logic [3:0] c, output logic acc);
      cnt = c;
      if (ld_q.size() > 0) begin
         ld_valid = 1'b1;
         ld_duty  = 4'(ld_q[0]);
      end else begin
         ld_valid = 1'b0;
      end
      acc = ld_valid && ld_ready;
      @(posedge clk);
      #1;
      if (acc) void'(ld_q.pop_front());
      if (ld_q.size() == 0) ld_valid = 1'b0;
   endtask

   task automatic run_seq(input int n, input int start, input int step, input int ub,
                          input int ld_at_a, input int ld_val_a,
                          input int ld_at_b, input int ld_val_b);
      logic acc;
      pwm_mask   = '0;
      match_mask = '0;
      wrap_mask  = '0;
      rdy_mask   = '0;
      acc_mask   = '0;
      for (int k = 0; k < n; k++) begin
         if (k == ld_at_a) ld_q.push_back(ld_val_a);
         if (k == ld_at_b) ld_q.push_back(ld_val_b);
         tick(4'((start + k * step) % ub), acc);
         pwm_mask   |= 32'(pwm) << k;
         match_mask |= 32'(match_pulse) << k;
         wrap_mask  |= 32'(wrap_pulse) << k;
         rdy_mask   |= 32'(ld_ready) << k;
         acc_mask   |= 32'(acc) << k;
      end
   endtask

   task automatic period(input int ld_at, input int ld_val);
      run_seq(10, 0, 1, 10, ld_at, ld_val, -1, 0);
   endtask

   initial begin
      logic acc;
      rst      = 1'b1;
      en       = 1'b0;
      ld_valid = 1'b0;
      ld_duty  = '0;
      cnt      = '0;
      tick(4'd0, acc);
      tick(4'd0, acc);

      chk("rst_pwm",      32'(pwm),         32'd0);
      chk("rst_wrap",     32'(wrap_pulse),  32'd0);
      chk("rst_match",    32'(match_pulse), 32'd0);
      chk("rst_running",  32'(running),     32'd0);
      chk("rst_period",   32'(period_cnt),  32'd0);
      chk("rst_ld_ready", 32'(ld_ready),    32'd1);

      // Enable mid-period: SYNC until the 9 -> 0 wrap.
      rst = 1'b0;
      en  = 1'b1;
      run_seq(5, 5, 1, 10, -1, 0, -1, 0);
      chk("sync_running", 32'(running),  32'd0);
      chk("sync_wrap",    wrap_mask,     32'h000);

      period(-1, 0);
      chk("first_wrap",   wrap_mask,     32'h001);
      chk("first_pwm",    pwm_mask,      32'h006);
      chk("first_match",  match_mask,    32'h008);
      chk("first_run",    32'(running),  32'd1);
      chk("first_period", 32'(period_cnt), 32'd0);

      period(-1, 0);
      chk("steady_pwm",    pwm_mask,   32'h007);
      chk("steady_match",  match_mask, 32'h008);
      chk("steady_wrap",   wrap_mask,  32'h001);
      chk("steady_period", 32'(period_cnt), 32'd1);

      // Shadow update: duty 7 loaded at sample 5.
      period(5, 7);
      chk("shadow_acc",   acc_mask,   32'h020);
      chk("shadow_rdy",   rdy_mask,   32'h01F);
      chk("shadow_pwm",   pwm_mask,   32'h007);
      chk("shadow_match", match_mask, 32'h008);
      period(-1, 0);
      chk("new7_pwm",   pwm_mask,   32'h07F);
      chk("new7_match", match_mask, 32'h080);
      chk("new7_rdy",   rdy_mask,   32'h3FF);

      // Back-pressure: 5 at sample 2, 8 offered at sample 4 while full.
      run_seq(10, 0, 1, 10, 2, 5, 4, 8);
      chk("bp_acc",    acc_mask, 32'h004);
      chk("bp_rdy",    rdy_mask, 32'h003);
      chk("bp_pwm",    pwm_mask, 32'h07F);
      chk("bp_held",   32'(ld_q.size()), 32'd1);
      chk("bp_valid",  32'(ld_valid), 32'd1);
      period(-1, 0);
      chk("bp5_acc",   acc_mask,   32'h002);
      chk("bp5_rdy",   rdy_mask,   32'h001);
      chk("bp5_pwm",   pwm_mask,   32'h01F);
      chk("bp5_match", match_mask, 32'h020);
      period(3, 0);
      chk("bp8_pwm",   pwm_mask,   32'h0FF);
      chk("bp8_match", match_mask, 32'h100);
      chk("bp8_period", 32'(period_cnt), 32'd6);

      // duty 0 then duty 15 (above every counter value).
      period(3, 15);
      chk("d0_pwm",   pwm_mask,   32'h000);
      chk("d0_match", match_mask, 32'h001);
      chk("d0_wrap",  wrap_mask,  32'h001);
      period(3, 5);
      chk("d15_pwm",   pwm_mask,   32'h3FF);
      chk("d15_match", match_mask, 32'h000);
      chk("d15_period", 32'(period_cnt), 32'd8);

      // Skipping counter STEP=3, UPPER_BOUND=16, duty 5:
      // 0,3,6,9,12,15,2,5,8,11,14
      run_seq(11, 0, 3, 16, -1, 0, -1, 0);
      chk("skip_wrap",   wrap_mask,  32'h041);
      chk("skip_match",  match_mask, 32'h084);
      chk("skip_pwm",    pwm_mask,   32'h043);
      chk("skip_period", 32'(period_cnt), 32'd10);

      // Drop en mid-period.
      run_seq(4, 0, 1, 10, -1, 0, -1, 0);
      chk("pre_off_pwm", pwm_mask, 32'h00F);
      en = 1'b0;
      tick(4'd4, acc);
      chk("off_pwm",     32'(pwm),         32'd0);
      chk("off_running", 32'(running),     32'd0);
      chk("off_wrap",    32'(wrap_pulse),  32'd0);
      chk("off_match",   32'(match_pulse), 32'd0);
      chk("off_period",  32'(period_cnt),  32'd11);
      tick(4'd9, acc);

      // Re-enable on a wrap cycle: IDLE -> SYNC without pulse, RUN at next wrap.
      en = 1'b1;
      run_seq(11, 0, 1, 10, -1, 0, -1, 0);
      chk("reen_wrap",    wrap_mask,  32'h400);
      chk("reen_pwm",     pwm_mask,   32'h000);
      chk("reen_match",   match_mask, 32'h000);
      chk("reen_running", 32'(running),    32'd1);
      chk("reen_period",  32'(period_cnt), 32'd11);

      // Fast wraps (1,0,1,0,...) roll period_cnt from 11 through 15 to 0.
      run_seq(10, 1, 1, 2, -1, 0, -1, 0);
      chk("roll_wrap",   wrap_mask, 32'h2AA);
      chk("roll_pwm",    pwm_mask,  32'h3FF);
      chk("roll_period", 32'(period_cnt), 32'd0);

      // Reset with the shadow full discards it; duty returns to 3.
      run_seq(1, 0, 1, 10, 0, 9, -1, 0);
      chk("prerst_rdy", 32'(ld_ready), 32'd0);
      rst = 1'b1;
      tick(4'd1, acc);
      chk("rst2_ld_ready", 32'(ld_ready),    32'd1);
      chk("rst2_pwm",      32'(pwm),         32'd0);
      chk("rst2_running",  32'(running),     32'd0);
      chk("rst2_period",   32'(period_cnt),  32'd0);
      chk("rst2_wrap",     32'(wrap_pulse),  32'd0);
      chk("rst2_match",    32'(match_pulse), 32'd0);
      rst = 1'b0;
      run_seq(5, 5, 1, 10, -1, 0, -1, 0);
      period(-1, 0);
      chk("post_rst_pwm",   pwm_mask,   32'h006);
      chk("post_rst_match", match_mask, 32'h008);
      period(-1, 0);
      chk("init_duty_pwm",   pwm_mask,   32'h007);
      chk("init_duty_match", match_mask, 32'h008);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
